cmd_tx_master: RTL and testbench
================================

# cmd_tx_master

Parametrised UART command transmitter that serialises an `NUM_BYTES`-byte command onto a single TX line, one 8N1 frame per byte, in a configurable byte order. It is the successor to the fixed two-byte command master: command width, byte order and baud divisor are parameters, and the whole command is latched at acceptance. It exposes a `busy` status, and requests arriving mid-transfer are ignored. It sits on the host/test side of the link and drives the command receiver of the device under control.

## Interface
- `NUM_BYTES`, 2: bytes per command, ≥1
- `BAUD_DIV`, 2604: clocks per bit (50 MHz / 19200), ≥2
- `MSB_FIRST`, 1: 1 sends `cmd[8*NUM_BYTES-1 -: 8]` first; 0 sends `cmd[7:0]` first
- `clk` in 1: system clock, all logic on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `snd_cmd` in 1: request to send; sampled only in IDLE/DONE
- `cmd` in 8*NUM_BYTES: command word; sampled only on the accept cycle
- `TX` out 1: serial line, idle high
- `busy` out 1: high from accept until last stop bit ends
- `cmd_cmplt` out 1: high from command completion until next accept

## Operation
- Master states: IDLE, SEND, DONE.
- IDLE/DONE + `snd_cmd`=1 → accept: latch full `cmd` into a byte shift register, load byte counter with NUM_BYTES-1, pulse `trmt` to the UART with the first byte, go to SEND, clear `cmd_cmplt`, set `busy`.
- SEND: on `tx_done` with counter ≠0: shift the next byte into position, decrement the counter, pulse `trmt` in the same cycle. On `tx_done` with counter =0: go to DONE, set `cmd_cmplt`, clear `busy`.
- `snd_cmd` in SEND is ignored. `cmd` changes after accept do not affect the transfer in flight.
- `snd_cmd` held high: a new command is accepted in the cycle after DONE is entered, so `cmd_cmplt` is high for exactly 1 cycle.
- UART framing: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts BAUD_DIV clocks. Frame = 10 bit times.
- `tx_done` is a 1-cycle pulse on the last clock of the stop bit.
- A new `trmt` on that clock starts the next start bit on the following clock, so there is no idle gap between bytes.
- Reset values: `TX`=1, `busy`=0, `cmd_cmplt`=0, state IDLE, all counters and shift registers 0.
- Reset mid-frame: `TX` returns high immediately (asynchronous). The partial command is discarded. The block is in IDLE after release.

## Timing
- Accept on cycle 0 → `TX` low (start bit) from cycle 1.
- Byte k (0-based) start bit begins at cycle 1 + 10·BAUD_DIV·k.
- `busy` high cycles 1 … 10·BAUD_DIV·NUM_BYTES.
- `cmd_cmplt` rises at cycle 1 + 10·BAUD_DIV·NUM_BYTES.
- `TX`, `busy` and `cmd_cmplt` are registered; there is no combinational path from inputs to outputs.
- Counter widths: baud counter $clog2(BAUD_DIV), bit counter 4 bits (0..9), byte counter $clog2(NUM_BYTES)+1 bits. The byte counter must not wrap with NUM_BYTES=1.

## Structure
- Package `cmd_tx_pkg`: master state enum (IDLE, SEND, DONE), `FRAME_BITS`=10, `DATA_BITS`=8.
- Sub-module `uart_tx`, parametrised by BAUD_DIV:
  - ports `clk`, `rst_n`, `trmt`, `tx_data[7:0]`, `TX`, `tx_done`
  - own states IDLE/TRANSMIT
  - 10-bit frame shift register, baud counter and bit counter
- Top level holds the master FSM, the command shift register and the byte counter.

## Test plan
- NUM_BYTES=2, MSB_FIRST=1, BAUD_DIV=4, `cmd`=16'hA55A, 1-cycle `snd_cmd` → decoded bytes A5 then 5A, no inter-byte gap, `cmd_cmplt` at cycle 81, `busy` low at cycle 81.
- Same config; second `snd_cmd` with `cmd`=16'h1234 at cycle 30 → ignored, line still carries A5, 5A; `cmd` changed to 16'hFFFF at cycle 2 → no effect.
- NUM_BYTES=3, MSB_FIRST=0, BAUD_DIV=4, `cmd`=24'h010203 → bytes 03, 02, 01; `cmd_cmplt` at cycle 121.
- NUM_BYTES=1, BAUD_DIV=2, `cmd`=8'h00 → TX low for cycles 1–18, high from cycle 19; `cmd_cmplt` at cycle 21; no counter wrap.
- `snd_cmd` held high, `cmd`=16'hC3C3, NUM_BYTES=2, BAUD_DIV=4 → back-to-back commands; `cmd_cmplt` high for 1 cycle at cycle 81; next start bit at cycle 82.
- Assert `rst_n`=0 at cycle 25 of a transfer → TX=1, `busy`=0, `cmd_cmplt`=0 immediately. After release, a new `cmd`=16'h0F0F transmits correctly from a clean state.

Source files
------------

// File: rtl/cmd_tx_pkg.sv
// Shared types and framing constants for the command transmitter.
// No logic; imported by the interface, the UART and the master.
package cmd_tx_pkg;
   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } mst_state_e;
endpackage

// File: rtl/cmd_tx_master_if.sv
// Host-side command bus: request/command in, serial line and status out.
// Purely wiring; master modport is the transmitter's view.
interface cmd_tx_master_if #(parameter int NUM_BYTES = 2);
   import cmd_tx_pkg::*;

   logic                           snd_cmd;
   logic [DATA_BITS*NUM_BYTES-1:0] cmd;
   logic                           TX;
   logic                           busy;
   logic                           cmd_cmplt;

   modport master (input snd_cmd, input cmd, output TX, output busy, output cmd_cmplt);
   modport slave  (output snd_cmd, output cmd, input TX, input busy, input cmd_cmplt);
endinterface

// File: rtl/cmd_tx_master_uart_tx.sv
// 8N1 serialiser: trmt loads a frame, TX drives the start bit on the next clock, 10*BAUD_DIV clocks per frame.
// No backpressure: trmt always reloads; tx_done pulses on the last clock of the stop bit so frames can abut.
module uart_tx
   import cmd_tx_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 trmt,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 TX,
   output logic                 tx_done
);
   localparam int            BW        = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

   typedef enum logic {TX_IDLE, TX_TRANSMIT} uart_state_e;

   uart_state_e           state_q, state_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [BW-1:0]         baud_q, baud_d;
   logic [3:0]            bit_q, bit_d;
   logic                  tx_q, tx_d;
   logic                  bit_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TX_IDLE;
         frame_q <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      bit_end = (state_q == TX_TRANSMIT) && (baud_q == BAUD_LAST);
      tx_done = bit_end && (bit_q == BIT_LAST);

      if (trmt) begin
         state_d = TX_TRANSMIT;
         frame_d = {1'b1, tx_data, 1'b0};
         baud_d  = '0;
         bit_d   = '0;
         tx_d    = 1'b0;
      end else if (tx_done) begin
         state_d = TX_IDLE;
         baud_d  = '0;
         bit_d   = '0;
         tx_d    = 1'b1;
      end else if (bit_end) begin
         // Rotate rather than shift so bit 0 is the line value of the current bit.
         frame_d = {frame_q[0], frame_q[FRAME_BITS-1:1]};
         baud_d  = '0;
         bit_d   = bit_q + 4'd1;
         tx_d    = frame_q[1];
      end else if (state_q == TX_TRANSMIT) begin
         baud_d = baud_q + BW'(1);
      end
   end

   assign TX = tx_q;
endmodule

// File: rtl/cmd_tx_master.sv
// Sends a NUM_BYTES command as back-to-back 8N1 frames; start bit one clock after accept, no gaps between bytes.
// No backpressure: snd_cmd is sampled only in IDLE/DONE, requests while sending are dropped.
module cmd_tx_master
   import cmd_tx_pkg::*;
#(
   parameter int NUM_BYTES = 2,
   parameter int BAUD_DIV  = 2604,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   cmd_tx_master_if.master bus
);
   localparam int CMD_W = DATA_BITS * NUM_BYTES;
   localparam int CNT_W = $clog2(NUM_BYTES) + 1;

   mst_state_e           state_q, state_d;
   logic [CMD_W-1:0]     shreg_q, shreg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 cmplt_q, cmplt_d;
   logic                 trmt;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_done;

   function automatic logic [DATA_BITS-1:0] first_byte(input logic [CMD_W-1:0] v);
      return MSB_FIRST ? v[CMD_W-1 -: DATA_BITS] : v[DATA_BITS-1:0];
   endfunction

   function automatic logic [CMD_W-1:0] drop_byte(input logic [CMD_W-1:0] v);
      return MSB_FIRST ? (v << DATA_BITS) : (v >> DATA_BITS);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         cmplt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         cmplt_q <= cmplt_d;
      end
   end

   // The shift register holds only the bytes not yet handed to the UART.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      cmplt_d = cmplt_q;
      trmt    = 1'b0;
      tx_data = '0;

      case (state_q)
         IDLE, DONE: begin
            if (bus.snd_cmd) begin
               trmt    = 1'b1;
               tx_data = first_byte(bus.cmd);
               shreg_d = drop_byte(bus.cmd);
               cnt_d   = CNT_W'(NUM_BYTES - 1);
               state_d = SEND;
               busy_d  = 1'b1;
               cmplt_d = 1'b0;
            end
         end
         SEND: begin
            if (tx_done) begin
               if (cnt_q != '0) begin
                  trmt    = 1'b1;
                  tx_data = first_byte(shreg_q);
                  shreg_d = drop_byte(shreg_q);
                  cnt_d   = cnt_q - CNT_W'(1);
               end else begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  cmplt_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .trmt    (trmt),
      .tx_data (tx_data),
      .TX      (bus.TX),
      .tx_done (tx_done)
   );

   assign bus.busy      = busy_q;
   assign bus.cmd_cmplt = cmplt_q;
endmodule

// File: tb/tb_cmd_tx_master.sv
// Bench for cmd_tx_master: three configurations, UART line decoder feeding a byte/timing scoreboard.
module tb_cmd_tx_master;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   t0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cmd_tx_master_if #(.NUM_BYTES(2)) ifa ();
   cmd_tx_master_if #(.NUM_BYTES(3)) ifb ();
   cmd_tx_master_if #(.NUM_BYTES(1)) ifc ();

   cmd_tx_master #(.NUM_BYTES(2), .BAUD_DIV(4), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   cmd_tx_master #(.NUM_BYTES(3), .BAUD_DIV(4), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   cmd_tx_master #(.NUM_BYTES(1), .BAUD_DIV(2), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   typedef struct { logic [7:0] b; int t; } exp_t;
   typedef struct { bit act; int cnt; logic [7:0] sh; int t_start; } dec_t;

   exp_t       q [3][$];
   dec_t       d [3];
   exp_t       e;
   bit         got, sok;
   logic [2:0] txv;
   int         bd [3] = '{4, 4, 2};

   assign txv = {ifc.TX, ifb.TX, ifa.TX};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int i, input logic [7:0] b, input int t);
      exp_t x;
      x.b = b;
      x.t = t;
      q[i].push_back(x);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Start detected on the first low sample; data and stop sampled mid-bit.
   function automatic void dec_step(inout dec_t dd, input logic tx, input int b, input int now,
                                    output bit g, output bit s);
      int i;
      g = 1'b0;
      s = 1'b0;
      if (!dd.act) begin
         if (tx === 1'b0) begin
            dd.act = 1'b1;
            dd.cnt = 0;
            dd.t_start = now;
         end
      end else begin
         dd.cnt++;
         if (dd.cnt % b == b / 2) begin
            i = dd.cnt / b;
            if (i >= 1 && i <= 8) dd.sh = {tx, dd.sh[7:1]};
            else if (i == 9) begin
               g = 1'b1;
               s = (tx === 1'b1);
               dd.act = 1'b0;
            end
         end
      end
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) d[i] = '{default: 0};
      end else begin
         for (int i = 0; i < 3; i++) begin
            dec_step(d[i], txv[i], bd[i], cyc, got, sok);
            if (got) begin
               chk($sformatf("dut%0d stop bit", i), {31'd0, sok}, 32'd1);
               if (q[i].size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL dut%0d unexpected byte: got %h, expected none", i, d[i].sh);
               end else begin
                  e = q[i].pop_front();
                  chk($sformatf("dut%0d byte value", i), {24'd0, d[i].sh}, {24'd0, e.b});
                  chk($sformatf("dut%0d byte start cycle", i), d[i].t_start, e.t);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected end of stimulus");
      $fatal(1);
   end

   initial begin
      ifa.snd_cmd = 1'b0; ifa.cmd = '0;
      ifb.snd_cmd = 1'b0; ifb.cmd = '0;
      ifc.snd_cmd = 1'b0; ifc.cmd = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset TX", ifa.TX, 1);
      chk("reset busy", ifa.busy, 0);
      chk("reset cmd_cmplt", ifa.cmd_cmplt, 0);
      chk("reset TX dut_c", ifc.TX, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic two-byte MSB-first command
      t0 = cyc;
      ifa.cmd = 16'hA55A; ifa.snd_cmd = 1'b1;
      push(0, 8'hA5, t0 + 1); push(0, 8'h5A, t0 + 41);
      @(negedge clk); ifa.snd_cmd = 1'b0;
      chk("t1 busy c1", ifa.busy, 1);
      chk("t1 start bit c1", ifa.TX, 0);
      wait_until(t0 + 80);
      chk("t1 busy c80", ifa.busy, 1);
      chk("t1 cmplt c80", ifa.cmd_cmplt, 0);
      wait_until(t0 + 81);
      chk("t1 cmplt c81", ifa.cmd_cmplt, 1);
      chk("t1 busy c81", ifa.busy, 0);
      wait_until(t0 + 85);

      // Mid-transfer request and cmd change must not disturb the frame
      t0 = cyc;
      ifa.cmd = 16'hA55A; ifa.snd_cmd = 1'b1;
      push(0, 8'hA5, t0 + 1); push(0, 8'h5A, t0 + 41);
      @(negedge clk); ifa.snd_cmd = 1'b0;
      chk("t2 cmplt cleared", ifa.cmd_cmplt, 0);
      wait_until(t0 + 2); ifa.cmd = 16'hFFFF;
      wait_until(t0 + 30); ifa.cmd = 16'h1234; ifa.snd_cmd = 1'b1;
      @(negedge clk); ifa.snd_cmd = 1'b0;
      wait_until(t0 + 81);
      chk("t2 cmplt c81", ifa.cmd_cmplt, 1);
      wait_until(t0 + 85);

      // snd_cmd held high: back-to-back commands
      t0 = cyc;
      ifa.cmd = 16'hC3C3; ifa.snd_cmd = 1'b1;
      push(0, 8'hC3, t0 + 1);  push(0, 8'hC3, t0 + 41);
      push(0, 8'hC3, t0 + 82); push(0, 8'hC3, t0 + 122);
      wait_until(t0 + 81);
      chk("t5 cmplt c81", ifa.cmd_cmplt, 1);
      chk("t5 busy c81", ifa.busy, 0);
      wait_until(t0 + 82);
      chk("t5 cmplt c82", ifa.cmd_cmplt, 0);
      chk("t5 busy c82", ifa.busy, 1);
      chk("t5 start bit c82", ifa.TX, 0);
      wait_until(t0 + 90); ifa.snd_cmd = 1'b0;
      wait_until(t0 + 161);
      chk("t5 cmplt c161", ifa.cmd_cmplt, 0);
      wait_until(t0 + 162);
      chk("t5 cmplt c162", ifa.cmd_cmplt, 1);
      wait_until(t0 + 166);

      // Asynchronous reset in the middle of byte 0 (bit 5 of 0x1E is 0)
      t0 = cyc;
      ifa.cmd = 16'h1E00; ifa.snd_cmd = 1'b1;
      @(negedge clk); ifa.snd_cmd = 1'b0;
      wait_until(t0 + 25);
      chk("t6 TX before reset", ifa.TX, 0);
      chk("t6 busy before reset", ifa.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t6 TX in reset", ifa.TX, 1);
      chk("t6 busy in reset", ifa.busy, 0);
      chk("t6 cmplt in reset", ifa.cmd_cmplt, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6 cmplt after release", ifa.cmd_cmplt, 0);
      chk("t6 TX after release", ifa.TX, 1);
      t0 = cyc;
      ifa.cmd = 16'h0F0F; ifa.snd_cmd = 1'b1;
      push(0, 8'h0F, t0 + 1); push(0, 8'h0F, t0 + 41);
      @(negedge clk); ifa.snd_cmd = 1'b0;
      wait_until(t0 + 81);
      chk("t6 cmplt c81", ifa.cmd_cmplt, 1);
      wait_until(t0 + 85);

      // Three bytes, LSB byte first
      t0 = cyc;
      ifb.cmd = 24'h010203; ifb.snd_cmd = 1'b1;
      push(1, 8'h03, t0 + 1); push(1, 8'h02, t0 + 41); push(1, 8'h01, t0 + 81);
      @(negedge clk); ifb.snd_cmd = 1'b0;
      wait_until(t0 + 120);
      chk("t3 cmplt c120", ifb.cmd_cmplt, 0);
      chk("t3 busy c120", ifb.busy, 1);
      wait_until(t0 + 121);
      chk("t3 cmplt c121", ifb.cmd_cmplt, 1);
      chk("t3 busy c121", ifb.busy, 0);
      wait_until(t0 + 125);

      // Single byte, BAUD_DIV=2
      t0 = cyc;
      ifc.cmd = 8'h00; ifc.snd_cmd = 1'b1;
      push(2, 8'h00, t0 + 1);
      @(negedge clk); ifc.snd_cmd = 1'b0;
      chk("t4 TX c1", ifc.TX, 0);
      wait_until(t0 + 18);
      chk("t4 TX c18", ifc.TX, 0);
      wait_until(t0 + 19);
      chk("t4 TX c19", ifc.TX, 1);
      wait_until(t0 + 20);
      chk("t4 cmplt c20", ifc.cmd_cmplt, 0);
      chk("t4 busy c20", ifc.busy, 1);
      wait_until(t0 + 21);
      chk("t4 cmplt c21", ifc.cmd_cmplt, 1);
      chk("t4 busy c21", ifc.busy, 0);
      wait_until(t0 + 30);
      chk("t4 no restart", ifc.TX, 1);

      chk("dut_a queue drained", q[0].size(), 0);
      chk("dut_b queue drained", q[1].size(), 0);
      chk("dut_c queue drained", q[2].size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
